// File: rtl/instr_fetch_unit_if.sv
// Fetch-unit bus: memory read port plus the instruction bundle handshake.
// master = fetch unit, slave = memory/consumer side.
interface instr_fetch_unit_if #(
    parameter int unsigned ADDR_W = 16
);
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_rd;
    logic              mem_ack;
    logic [15:0]       mem_rdata;
    logic [15:0]       instruction;
    logic [15:0]       instruction_1;
    logic [15:0]       instruction_2;
    logic [1:0]        inst_len;
    logic [ADDR_W-1:0] inst_pc;
    logic              inst_valid;
    logic              inst_ack;
    logic              branch_take;
    logic              illegal_op;

    modport master (
        output mem_addr, mem_rd,
        input  mem_ack, mem_rdata,
        output instruction, instruction_1, instruction_2, inst_len, inst_pc, inst_valid,
        input  inst_ack, branch_take,
        output illegal_op
    );

    modport slave (
        input  mem_addr, mem_rd,
        output mem_ack, mem_rdata,
        input  instruction, instruction_1, instruction_2, inst_len, inst_pc, inst_valid,
        output inst_ack, branch_take,
        input  illegal_op
    );
endinterface

// File: rtl/instr_fetch_unit.sv
// MSP430-style fetch stage: reads 1-3 words per instruction, owns the PC, no prefetch.
// Optional macro IFU_ILLEGAL_TRAP_EN: opcode nibble 0 raises illegal_op and redirects to TRAP_VEC.
module instr_fetch_unit #(
    parameter int unsigned       ADDR_W   = 16,
    parameter logic [ADDR_W-1:0] PC_RESET = ADDR_W'(16'h0000),
    parameter logic [ADDR_W-1:0] TRAP_VEC = ADDR_W'(16'hFFFE)
) (
    input logic                clk,
    input logic                rst,
    instr_fetch_unit_if.master bus
);

    typedef enum logic [1:0] {FETCH0, FETCH1, FETCH2, HOLD} state_t;

    state_t            state;
    logic [ADDR_W-1:0] pc;
    logic [1:0]        fetch_len;
    logic              is_jump;
    logic [ADDR_W-1:0] jump_off;
    logic [ADDR_W-1:0] next_pc;

    // Instruction length from the opcode word: extension words for immediate/indexed operands.
    function automatic logic [1:0] decode_len(input logic [15:0] w);
        logic [1:0] len;
        len = 2'd1;
        if (w[15:12] >= 4'd4) begin
            if (w[5:4] == 2'b01 || (w[5:4] == 2'b11 && w[11:8] == 4'd0)) len = len + 2'd1;
            if (w[7]) len = len + 2'd1;
        end else if (w[15:12] == 4'd1) begin
            if (w[5:4] == 2'b01 || (w[5:4] == 2'b11 && w[3:0] == 4'd0)) len = 2'd2;
        end
        return len;
    endfunction

    always_comb begin
        fetch_len = decode_len(bus.mem_rdata);
        is_jump   = (bus.instruction[15:13] == 3'b001);
        jump_off  = ADDR_W'($signed({bus.instruction[9:0], 1'b0}));
        if (bus.illegal_op)
            next_pc = TRAP_VEC;
        else if (bus.branch_take && is_jump)
            next_pc = bus.inst_pc + ADDR_W'(2) + jump_off;
        else
            next_pc = bus.inst_pc + ADDR_W'({bus.inst_len, 1'b0});
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state             <= FETCH0;
            pc                <= PC_RESET;
            bus.mem_addr      <= PC_RESET;
            bus.mem_rd        <= 1'b0;
            bus.inst_valid    <= 1'b0;
            bus.instruction   <= 16'h0000;
            bus.instruction_1 <= 16'h0000;
            bus.instruction_2 <= 16'h0000;
            bus.inst_len      <= 2'd0;
            bus.inst_pc       <= '0;
            bus.illegal_op    <= 1'b0;
        end else begin
            case (state)
                FETCH0: begin
                    // mem_rd is only low here right after reset; any stray ack is ignored
                    if (!bus.mem_rd) begin
                        bus.mem_rd <= 1'b1;
                    end else if (bus.mem_ack) begin
                        bus.instruction   <= bus.mem_rdata;
                        bus.instruction_1 <= 16'h0000;
                        bus.instruction_2 <= 16'h0000;
                        bus.inst_len      <= fetch_len;
                        bus.inst_pc       <= pc;
`ifdef IFU_ILLEGAL_TRAP_EN
                        bus.illegal_op    <= (bus.mem_rdata[15:12] == 4'd0);
`else
                        bus.illegal_op    <= 1'b0;
`endif
                        if (fetch_len == 2'd1) begin
                            state          <= HOLD;
                            bus.mem_rd     <= 1'b0;
                            bus.inst_valid <= 1'b1;
                        end else begin
                            state        <= FETCH1;
                            bus.mem_addr <= pc + ADDR_W'(2);
                        end
                    end
                end
                FETCH1: begin
                    if (bus.mem_ack) begin
                        bus.instruction_1 <= bus.mem_rdata;
                        if (bus.inst_len == 2'd2) begin
                            state          <= HOLD;
                            bus.mem_rd     <= 1'b0;
                            bus.inst_valid <= 1'b1;
                        end else begin
                            state        <= FETCH2;
                            bus.mem_addr <= pc + ADDR_W'(4);
                        end
                    end
                end
                FETCH2: begin
                    if (bus.mem_ack) begin
                        bus.instruction_2 <= bus.mem_rdata;
                        state             <= HOLD;
                        bus.mem_rd        <= 1'b0;
                        bus.inst_valid    <= 1'b1;
                    end
                end
                HOLD: begin
                    // Accepted bundle: redirect PC and start the next read right away
                    if (bus.inst_ack) begin
                        state          <= FETCH0;
                        pc             <= next_pc;
                        bus.mem_addr   <= next_pc;
                        bus.mem_rd     <= 1'b1;
                        bus.inst_valid <= 1'b0;
                    end
                end
                default: state <= FETCH0;
            endcase
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: zero-wait and delayed memory, jumps, async reset.
module tb_instr_fetch_unit;

    logic        clk;
    logic        rst;
    logic [15:0] mem [128];
    int          ack_delay;
    int          wait_cnt;
    logic        force_ack;
    int          total;
    int          bad;
    logic [15:0] exp_next;
    logic [15:0] exp_f1;
    logic        exp_ill;

    instr_fetch_unit_if #(.ADDR_W(16)) bus ();

    instr_fetch_unit #(.ADDR_W(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: ack after ack_delay wait cycles of a held request
    always @(posedge clk) begin
        if (bus.mem_rd && !bus.mem_ack) wait_cnt <= wait_cnt + 1;
        else                            wait_cnt <= 0;
    end
    assign bus.mem_ack   = force_ack || (bus.mem_rd && (wait_cnt >= ack_delay));
    assign bus.mem_rdata = mem[bus.mem_addr[7:1]];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_valid(input string tag);
        int n;
        n = 0;
        while (!bus.inst_valid && n < 60) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_valid"}, 32'(bus.inst_valid), 32'd1);
    endtask

    task automatic check_bundle(input string tag, input logic [15:0] i0, input logic [15:0] i1,
                                input logic [15:0] i2, input logic [1:0] len, input logic [15:0] pc,
                                input logic ill);
        check({tag, "_instr"}, 32'(bus.instruction), 32'(i0));
        check({tag, "_instr1"}, 32'(bus.instruction_1), 32'(i1));
        check({tag, "_instr2"}, 32'(bus.instruction_2), 32'(i2));
        check({tag, "_len"}, 32'(bus.inst_len), 32'(len));
        check({tag, "_pc"}, 32'(bus.inst_pc), 32'(pc));
        check({tag, "_ill"}, 32'(bus.illegal_op), 32'(ill));
    endtask

    task automatic do_ack(input logic bt);
        bus.branch_take = bt;
        bus.inst_ack    = 1'b1;
        @(negedge clk);
        bus.inst_ack    = 1'b0;
        bus.branch_take = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic        prev_wait;
        logic [15:0] prev_addr;
        int          n;
        total = 0;
        bad   = 0;
        for (int i = 0; i < 128; i++) mem[i] = 16'h0000;
        mem[0]   = 16'h4035; mem[1]  = 16'h1234;
        mem[2]   = 16'h5495; mem[3]  = 16'h0010; mem[4]  = 16'h0020;
        mem[5]   = 16'h4303;
        mem[6]   = 16'h12B0; mem[7]  = 16'hABCD;
        mem[8]   = 16'h3FFF;
        mem[9]   = 16'h5495; mem[10] = 16'h1111; mem[11] = 16'h2222;
        mem[12]  = 16'h0000;
        mem[13]  = 16'h5495;
        mem[127] = 16'h5495;
`ifdef IFU_ILLEGAL_TRAP_EN
        exp_next = 16'hFFFE;
        exp_ill  = 1'b1;
`else
        exp_next = 16'h001A;
        exp_ill  = 1'b0;
`endif
        exp_f1 = exp_next + 16'h0002;

        rst = 1'b1; ack_delay = 0; force_ack = 1'b0;
        bus.inst_ack = 1'b0; bus.branch_take = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_mem_rd", 32'(bus.mem_rd), 32'd0);
        check("rst_mem_addr", 32'(bus.mem_addr), 32'h0000);
        check("rst_valid", 32'(bus.inst_valid), 32'd0);
        check_bundle("rst", 16'h0, 16'h0, 16'h0, 2'd0, 16'h0, 1'b0);

        // Reset release: first cycle issues a read of the reset vector
        rst = 1'b0;
        @(negedge clk);
        check("start_mem_rd", 32'(bus.mem_rd), 32'd1);
        check("start_mem_addr", 32'(bus.mem_addr), 32'h0000);

        wait_valid("mov_imm");
        check_bundle("mov_imm", 16'h4035, 16'h1234, 16'h0000, 2'd2, 16'h0000, 1'b0);
        do_ack(1'b0);
        check("mov_next_addr", 32'(bus.mem_addr), 32'h0004);
        check("mov_valid_drop", 32'(bus.inst_valid), 32'd0);

        wait_valid("add_idx");
        check_bundle("add_idx", 16'h5495, 16'h0010, 16'h0020, 2'd3, 16'h0004, 1'b0);
        do_ack(1'b0);
        check("add_next_addr", 32'(bus.mem_addr), 32'h000A);

        wait_valid("nop");
        check_bundle("nop", 16'h4303, 16'h0000, 16'h0000, 2'd1, 16'h000A, 1'b0);
        do_ack(1'b1);
        check("nop_bt_next_addr", 32'(bus.mem_addr), 32'h000C);

        wait_valid("call_imm");
        check_bundle("call_imm", 16'h12B0, 16'hABCD, 16'h0000, 2'd2, 16'h000C, 1'b0);
        do_ack(1'b0);
        check("call_next_addr", 32'(bus.mem_addr), 32'h0010);

        wait_valid("jmp_self");
        check_bundle("jmp_self", 16'h3FFF, 16'h0000, 16'h0000, 2'd1, 16'h0010, 1'b0);
        do_ack(1'b1);
        check("jmp_taken_addr", 32'(bus.mem_addr), 32'h0010);

        wait_valid("jmp_again");
        check("jmp_again_pc", 32'(bus.inst_pc), 32'h0010);
        ack_delay = 3;
        do_ack(1'b0);
        check("jmp_not_taken_addr", 32'(bus.mem_addr), 32'h0012);

        // Slow memory: request must stay put while waiting for ack
        prev_wait = 1'b0;
        prev_addr = 16'h0;
        n = 0;
        while (!bus.inst_valid && n < 60) begin
            if (prev_wait) begin
                check("slow_addr_stable", 32'(bus.mem_addr), 32'(prev_addr));
                check("slow_rd_stable", 32'(bus.mem_rd), 32'd1);
            end
            prev_wait = bus.mem_rd && !bus.mem_ack;
            prev_addr = bus.mem_addr;
            @(negedge clk);
            n++;
        end
        check("slow_valid", 32'(bus.inst_valid), 32'd1);
        for (int i = 0; i < 5; i++) begin
            check_bundle("slow_hold", 16'h5495, 16'h1111, 16'h2222, 2'd3, 16'h0012, 1'b0);
            check("slow_hold_valid", 32'(bus.inst_valid), 32'd1);
            check("slow_hold_no_rd", 32'(bus.mem_rd), 32'd0);
            @(negedge clk);
        end
        ack_delay = 0;
        do_ack(1'b1);
        check("slow_next_addr", 32'(bus.mem_addr), 32'h0018);

        wait_valid("op0");
        check_bundle("op0", 16'h0000, 16'h0000, 16'h0000, 2'd1, 16'h0018, exp_ill);
        ack_delay = 3;
        do_ack(1'b1);
        check("op0_next_addr", 32'(bus.mem_addr), 32'(exp_next));

        // Async reset while the second word of a 3-word op is outstanding
        n = 0;
        while (!(bus.mem_rd && bus.mem_addr == exp_f1) && n < 60) begin
            @(negedge clk);
            n++;
        end
        check("reach_fetch1", 32'(bus.mem_addr), 32'(exp_f1));
        #2;
        rst       = 1'b1;
        force_ack = 1'b1;
        ack_delay = 0;
        #1;
        check("async_rst_rd", 32'(bus.mem_rd), 32'd0);
        check("async_rst_addr", 32'(bus.mem_addr), 32'h0000);
        @(negedge clk);
        check_bundle("in_rst", 16'h0, 16'h0, 16'h0, 2'd0, 16'h0, 1'b0);
        rst = 1'b0;
        @(negedge clk);
        check("restart_rd", 32'(bus.mem_rd), 32'd1);
        check("restart_addr", 32'(bus.mem_addr), 32'h0000);
        check("late_ack_ignored", 32'(bus.instruction), 32'h0000);
        force_ack = 1'b0;
        wait_valid("restart");
        check_bundle("restart", 16'h4035, 16'h1234, 16'h0000, 2'd2, 16'h0000, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
